// File: rtl/hpu_bundle_pkg.sv
// Shared types and saturating arithmetic helpers for the HPU bundling accumulator.
// The helpers work on 32-bit containers, so counter widths up to 32 bits are supported.
package hpu_bundle_pkg;

  typedef enum logic [0:0] {
    ST_ACC  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  // Signed +1 (dn=0) or -1 (dn=1) step clamped to a w-bit two's complement range.
  // Bit 32 of the result flags a clamp; bits [31:0] hold the stepped value.
  function automatic logic [32:0] sat_step(input logic [31:0] val, input logic dn,
                                           input int unsigned w);
    logic signed [31:0] s_val;
    logic signed [31:0] s_max;
    logic signed [31:0] s_min;
    s_val = signed'(val);
    s_max = signed'((32'd1 << (w - 1)) - 32'd1);
    s_min = ~s_max;
    if (dn) begin
      if (s_val == s_min) return {1'b1, val};
      else                return {1'b0, val - 32'd1};
    end else begin
      if (s_val == s_max) return {1'b1, val};
      else                return {1'b0, val + 32'd1};
    end
  endfunction

  // Unsigned increment that sticks at 2^w-1.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned w);
    logic [31:0] mx;
    if (w >= 32) mx = '1;
    else         mx = (32'd1 << w) - 32'd1;
    return (val == mx) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/bundle_counter_array_lane.sv
// One saturating signed vote counter: +1 on a 0 bit, -1 on a 1 bit.
// sign reflects the value the counter will hold after this cycle's step.
module bundle_lane
  import hpu_bundle_pkg::*;
#(
  parameter int W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic step_en,
  input  logic bit_in,
  input  logic zero,
  output logic sign,
  output logic clamped
);

  logic [W-1:0] r_cnt;
  logic [32:0]  w_step;
  logic [32:0]  w_unused_step;
  logic [W-1:0] w_next;

  assign w_step        = sat_step(32'(signed'(r_cnt)), bit_in, W);
  assign w_unused_step = w_step;
  assign w_next        = step_en ? w_step[W-1:0] : r_cnt;
  assign sign          = w_next[W-1];
  assign clamped       = step_en & w_step[32];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_cnt <= '0;
    else if (zero) r_cnt <= '0;
    else           r_cnt <= w_next;
  end

endmodule

// File: rtl/bundle_counter_array.sv
// D-lane majority bundler: accumulates beats until in_last, then holds the
// sign-bit vector, beat count and sticky clamp flag until the consumer takes them.
module bundle_counter_array
  import hpu_bundle_pkg::*;
#(
  parameter int D = 32,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [D-1:0] in_vec,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [D-1:0] out_vec,
  output logic [W-1:0] n_count,
  output logic         sat
);

  state_t       r_state;
  logic [D-1:0] r_out_vec;
  logic [W-1:0] r_n_count;
  logic         r_sat;

  logic         w_accept;
  logic         w_release;
  logic         w_zero;
  logic [D-1:0] w_sign;
  logic [D-1:0] w_clamped;
  logic [31:0]  w_n_inc;
  logic [31:0]  w_unused_n_inc;

  // clear wins over everything, so a beat in the clear cycle is never accepted
  assign w_accept       = in_valid & (r_state == ST_ACC) & ~clear;
  assign w_release      = (r_state == ST_DONE) & out_ready;
  assign w_zero         = clear | w_release;
  assign w_n_inc        = sat_inc(32'(r_n_count), W);
  assign w_unused_n_inc = w_n_inc;

  generate
    for (genvar gi = 0; gi < D; gi++) begin : g_lane
      bundle_lane #(.W(W)) u_lane (
        .clk     (clk),
        .rst     (rst),
        .step_en (w_accept),
        .bit_in  (in_vec[gi]),
        .zero    (w_zero),
        .sign    (w_sign[gi]),
        .clamped (w_clamped[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_ACC;
    end else if (clear) begin
      r_state <= ST_ACC;
    end else begin
      case (r_state)
        ST_ACC:  if (w_accept && in_last) r_state <= ST_DONE;
        ST_DONE: if (out_ready)           r_state <= ST_ACC;
        default: r_state <= ST_ACC;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       r_out_vec <= '0;
    else if (w_accept && in_last)  r_out_vec <= w_sign;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_n_count <= '0;
    else if (w_zero)   r_n_count <= '0;
    else if (w_accept) r_n_count <= w_n_inc[W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            r_sat <= 1'b0;
    else if (w_zero)                    r_sat <= 1'b0;
    else if (w_accept && |w_clamped)    r_sat <= 1'b1;
  end

  assign in_ready  = (r_state == ST_ACC);
  assign out_valid = (r_state == ST_DONE);
  assign out_vec   = r_out_vec;
  assign n_count   = r_n_count;
  assign sat       = r_sat;

endmodule
